obstacle_scheduler: RTL and testbench

- Upstream of the display/compositing stage; replaces the free-running scroll counter.
- Once per video frame it advances the ground scroll position and moves up to three obstacle slots leftward.
- It spawns new obstacles with random type and gap, and ramps speed with distance.
- Halts on collision and reinitialises on restart; the compositing stage only draws what it receives.

---
 rtl/dino_pkg.sv | 27 ++
 rtl/obstacle_slot.sv | 76 +++++++
 rtl/obstacle_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_obstacle_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// dino_pkg: definitions shared by the obstacle scheduler and its slot sub-module.
//   obstacle_t      : obstacle kind carried per slot (2 bits)
//   sched_state_t   : scheduler FSM states
//   SCREEN_W/H      : visible screen size in pixels
//   X_OFFSET        : slot_x encodes screen x + X_OFFSET so that x never goes negative
//   SLOT_X_W        : width of one slot x coordinate
package dino_pkg;

  typedef enum logic [1:0] {
    CACTUS1  = 2'd0,
    CACTUS2  = 2'd1,
    CACTUS3  = 2'd2,
    ASTEROID = 2'd3
  } obstacle_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } sched_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_OFFSET = 64;
  localparam int SLOT_X_W = 11;

endpackage

// File: rtl/obstacle_slot.sv
// obstacle_slot: one obstacle slot (active flag, x position, type).
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   clear           : drop the obstacle (restart); x/type are held
//   spawn           : load a new obstacle at spawn_x with spawn_type
//   step            : frame advance; move left by speed or retire
//   speed           : pixels per frame
//   spawn_type      : type loaded on spawn
//   spawn_x         : x loaded on spawn
//   active, x, obs_type : registered slot contents
// Retirement is decided combinationally: an active slot whose x is not
// greater than speed would cross x=0 this frame, so it is dropped instead of
// being subtracted (the subtraction therefore never underflows).
module obstacle_slot
  import dino_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                spawn,
  input  logic                step,
  input  logic [3:0]          speed,
  input  logic [1:0]          spawn_type,
  input  logic [SLOT_X_W-1:0] spawn_x,
  output logic                active,
  output logic [SLOT_X_W-1:0] x,
  output logic [1:0]          obs_type
);

  logic                active_q, active_d;
  logic [SLOT_X_W-1:0] x_q, x_d;
  obstacle_t           type_q, type_d;
  logic                retire_s;

  assign retire_s = active_q && (x_q <= {7'd0, speed});

  // next-state: clear beats spawn beats step
  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    type_d   = type_q;
    if (clear) begin
      active_d = 1'b0;
    end else if (spawn) begin
      active_d = 1'b1;
      x_d      = spawn_x;
      type_d   = obstacle_t'(spawn_type);
    end else if (step && active_q) begin
      if (retire_s) begin
        active_d = 1'b0;
      end else begin
        x_d = x_q - {7'd0, speed};
      end
    end else begin
      active_d = active_q;
    end
  end

  // slot state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      x_q      <= '0;
      type_q   <= CACTUS1;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      type_q   <= type_d;
    end
  end

  assign active   = active_q;
  assign x        = x_q;
  assign obs_type = type_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: per-frame scroll / obstacle scheduler for the runner game.
// Once per frame_tick in RUN it advances scroll_pos by speed, moves the three
// obstacle slots left, spawns into the lowest free slot when the gap counter
// expires, and (optionally) ramps speed with distance.
// Ports:
//   clk, reset_n  : pixel clock, asynchronous active-low reset
//   frame_tick    : one pulse per frame
//   halt          : collision level; RUN -> HALTED
//   restart       : reinitialise and enter RUN (highest priority)
//   rnd           : random bits, [1:0] = type, [4:2] = extra gap units
//   running       : high in RUN
//   scroll_pos    : ground scroll offset (mod 2048)
//   speed         : pixels per frame
//   slot_active   : per-slot valid bits
//   slot_type     : 2 bits per slot
//   slot_x        : 11 bits per slot, screen x + 64
// Build option: define SCHED_SPEED_RAMP_EN to enable the speed ramp; without
// it speed is fixed at INIT_SPEED and no ramp counter exists.
module obstacle_scheduler
  import dino_pkg::*;
#(
  parameter int NUM_SLOTS         = 3,
  parameter int INIT_SPEED        = 2,
  parameter int MAX_SPEED         = 8,
  parameter int SPEED_STEP_FRAMES = 600,
  parameter int INIT_GAP          = 60,
  parameter int MIN_GAP           = 40,
  parameter int GAP_STEP          = 8,
  parameter int SPAWN_X           = 704
)
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        halt,
  input  logic        restart,
  input  logic [4:0]  rnd,
  output logic        running,
  output logic [10:0] scroll_pos,
  output logic [3:0]  speed,
  output logic [2:0]  slot_active,
  output logic [5:0]  slot_type,
  output logic [32:0] slot_x
);

  sched_state_t state_q, state_d;
  logic [10:0]  scroll_q, scroll_d;
  logic [7:0]   gap_q, gap_d;
  logic [3:0]   speed_s;
  logic [2:0]   free_s, spawn_sel_s, spawn_vec_s;
  logic         advance_s, do_spawn_s;

  // a frame advance happens only in RUN with nothing higher priority pending
  assign advance_s  = (state_q == S_RUN) && frame_tick && !halt && !restart;
  assign free_s     = ~slot_active;
  assign do_spawn_s = advance_s && (gap_q == 8'd0) && (free_s != 3'd0);
  assign spawn_vec_s = do_spawn_s ? spawn_sel_s : 3'd0;

  // lowest-index free slot (uses active bits before this tick's retirements)
  always_comb begin
    spawn_sel_s = 3'b000;
    if (free_s[0]) begin
      spawn_sel_s = 3'b001;
    end else if (free_s[1]) begin
      spawn_sel_s = 3'b010;
    end else if (free_s[2]) begin
      spawn_sel_s = 3'b100;
    end else begin
      spawn_sel_s = 3'b000;
    end
  end

  // FSM, scroll and gap next-state
  always_comb begin
    state_d  = state_q;
    scroll_d = scroll_q;
    gap_d    = gap_q;
    if (restart) begin
      state_d  = S_RUN;
      scroll_d = 11'd0;
      gap_d    = 8'(INIT_GAP);
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_IDLE;
        S_RUN:    state_d = halt ? S_HALTED : S_RUN;
        S_HALTED: state_d = S_HALTED;
        default:  state_d = S_IDLE;
      endcase
      if (advance_s) begin
        scroll_d = scroll_q + {7'd0, speed_s};
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (do_spawn_s) begin
          gap_d = 8'(MIN_GAP) + 8'(rnd[4:2]) * 8'(GAP_STEP);
        end else begin
          gap_d = 8'd0;  // all slots full: retry next tick
        end
      end else begin
        scroll_d = scroll_q;
      end
    end
  end

  // FSM, scroll and gap registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      scroll_q <= 11'd0;
      gap_q    <= 8'(INIT_GAP);
    end else begin
      state_q  <= state_d;
      scroll_q <= scroll_d;
      gap_q    <= gap_d;
    end
  end

`ifdef SCHED_SPEED_RAMP_EN
  logic [9:0] ramp_q, ramp_d;
  logic [3:0] speed_q, speed_d;

  // speed ramp: one step every SPEED_STEP_FRAMES advanced frames, saturating
  always_comb begin
    ramp_d  = ramp_q;
    speed_d = speed_q;
    if (restart) begin
      ramp_d  = 10'd0;
      speed_d = 4'(INIT_SPEED);
    end else if (advance_s) begin
      if (ramp_q == 10'(SPEED_STEP_FRAMES - 1)) begin
        ramp_d = 10'd0;
        if (speed_q < 4'(MAX_SPEED)) begin
          speed_d = speed_q + 4'd1;
        end else begin
          speed_d = speed_q;
        end
      end else begin
        ramp_d = ramp_q + 10'd1;
      end
    end else begin
      ramp_d = ramp_q;
    end
  end

  // ramp and speed registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramp_q  <= 10'd0;
      speed_q <= 4'(INIT_SPEED);
    end else begin
      ramp_q  <= ramp_d;
      speed_q <= speed_d;
    end
  end

  assign speed_s = speed_q;
`else
  assign speed_s = 4'(INIT_SPEED);
`endif

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    obstacle_slot u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (restart),
      .spawn      (spawn_vec_s[i]),
      .step       (advance_s),
      .speed      (speed_s),
      .spawn_type (rnd[1:0]),
      .spawn_x    (11'(SPAWN_X)),
      .active     (slot_active[i]),
      .x          (slot_x[i*11 +: 11]),
      .obs_type   (slot_type[i*2 +: 2])
    );
  end

  assign running    = (state_q == S_RUN);
  assign scroll_pos = scroll_q;
  assign speed      = speed_s;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: random frame_tick/halt/restart/rnd
// stimulus compared every cycle against a frame-level reference model.
module tb_obstacle_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        halt = 1'b0;
  logic        restart = 1'b0;
  logic [4:0]  rnd = 5'd0;
  logic        running;
  logic [10:0] scroll_pos;
  logic [3:0]  speed;
  logic [2:0]  slot_active;
  logic [5:0]  slot_type;
  logic [32:0] slot_x;

  obstacle_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .halt        (halt),
    .restart     (restart),
    .rnd         (rnd),
    .running     (running),
    .scroll_pos  (scroll_pos),
    .speed       (speed),
    .slot_active (slot_active),
    .slot_type   (slot_type),
    .slot_x      (slot_x)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: 0 idle, 1 run, 2 halted
  int m_state, m_scroll, m_speed, m_gap, m_ramp;
  int m_act[3];
  int m_x[3];
  int m_type[3];
`ifdef SCHED_SPEED_RAMP_EN
  bit ramp_en = 1'b1;
`else
  bit ramp_en = 1'b0;
`endif

  task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_scroll = 0; m_speed = 2; m_gap = 60; m_ramp = 0;
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_type[i] = 0;
    end
  endtask

  // one clock edge of the frame-level rules, using the inputs present at the edge
  task automatic model_clock();
    int free_idx;
    if (restart) begin
      for (int i = 0; i < 3; i++) m_act[i] = 0;
      m_scroll = 0; m_speed = 2; m_gap = 60; m_ramp = 0; m_state = 1;
    end else if (m_state == 1 && halt) begin
      m_state = 2;
    end else if (m_state == 1 && frame_tick) begin
      free_idx = -1;
      for (int i = 2; i >= 0; i--) if (m_act[i] == 0) free_idx = i;
      for (int i = 0; i < 3; i++) begin
        if (m_act[i] != 0) begin
          if (m_x[i] > m_speed) m_x[i] = m_x[i] - m_speed;
          else m_act[i] = 0;
        end
      end
      if (m_gap == 0) begin
        if (free_idx >= 0) begin
          m_act[free_idx] = 1;
          m_x[free_idx] = 704;
          m_type[free_idx] = int'(rnd[1:0]);
          m_gap = 40 + int'(rnd[4:2]) * 8;
        end
      end else begin
        m_gap = m_gap - 1;
      end
      m_scroll = (m_scroll + m_speed) % 2048;
      if (ramp_en) begin
        if (m_ramp == 599) begin
          m_ramp = 0;
          if (m_speed < 8) m_speed = m_speed + 1;
        end else begin
          m_ramp = m_ramp + 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    longint unsigned ea, et, ex;
    ea = 0; et = 0; ex = 0;
    for (int i = 0; i < 3; i++) begin
      ea = ea | (longint'(m_act[i]) << i);
      et = et | (longint'(m_type[i]) << (2 * i));
      ex = ex | (longint'(m_x[i]) << (11 * i));
    end
    check_eq("running", running, (m_state == 1) ? 1 : 0);
    check_eq("scroll_pos", scroll_pos, m_scroll);
    check_eq("speed", speed, m_speed);
    check_eq("slot_active", slot_active, ea);
    check_eq("slot_type", slot_type, et);
    check_eq("slot_x", slot_x, ex);
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  int max_speed_seen;
  int full_seen;

  initial begin
    model_reset();
    #5;
    compare_all();
    check_eq("reset_speed", speed, 2);
    @(negedge clk);
    reset_n = 1'b1;

    // IDLE ignores ticks and halt
    for (int i = 0; i < 20; i++) begin
      frame_tick = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1));
      rnd = 5'($urandom);
      run_cycle();
    end
    check_eq("idle_running", running, 0);

    // restart wins over halt and frame_tick
    restart = 1'b1; halt = 1'b1; frame_tick = 1'b1;
    run_cycle();
    restart = 1'b0; halt = 1'b0;
    check_eq("restart_running", running, 1);

    // long run: spawns, full slots, retirements, speed ramp
    max_speed_seen = 0; full_seen = 0;
    for (int i = 0; i < 4200; i++) begin
      frame_tick = ($urandom_range(0, 7) != 0);
      rnd = 5'($urandom);
      run_cycle();
      if (int'(speed) > max_speed_seen) max_speed_seen = int'(speed);
      if (slot_active == 3'b111) full_seen = 1;
    end
    check_eq("max_speed", max_speed_seen, ramp_en ? 8 : 2);

    // halt coincident with a tick: frozen afterwards
    halt = 1'b1; frame_tick = 1'b1;
    run_cycle();
    for (int i = 0; i < 100; i++) begin
      halt = 1'($urandom_range(0, 1));
      frame_tick = 1'b1;
      rnd = 5'($urandom);
      run_cycle();
    end
    check_eq("halted_running", running, 0);

    restart = 1'b1; halt = 1'b0;
    run_cycle();
    restart = 1'b0;
    check_eq("restart2_running", running, 1);
    check_eq("restart2_scroll", scroll_pos, 0);
    check_eq("restart2_active", slot_active, 0);
    check_eq("restart2_speed", speed, 2);

    // mixed traffic with an asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      frame_tick = ($urandom_range(0, 3) != 0);
      halt = ($urandom_range(0, 299) == 0);
      restart = ($urandom_range(0, 399) == 0);
      rnd = 5'($urandom);
      if (i == 1500) begin
        restart = 1'b1; halt = 1'b0;
      end
      if (i == 1800) begin
        restart = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        run_cycle();
      end
    end
    restart = 1'b0; halt = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
